// File: rtl/data_mem_arbiter_if.sv
// Request/ack bus for the two data-memory ports plus the memory pin bundle.
// slave = arbiter side, master = requesters and memory model side.
interface data_mem_arbiter_if #(
   parameter int ADDR_W = 32
);
   logic              p0_req;
   logic              p0_we;
   logic [ADDR_W-1:0] p0_addr;
   logic [31:0]       p0_wdata;
   logic              p0_ack;
   logic              p0_err;
   logic [31:0]       p0_rdata;

   logic              p1_req;
   logic              p1_we;
   logic [ADDR_W-1:0] p1_addr;
   logic [31:0]       p1_wdata;
   logic              p1_ack;
   logic              p1_err;
   logic [31:0]       p1_rdata;

   logic [ADDR_W-1:0] mem_address;
   logic [31:0]       mem_writeData;
   logic              mem_memWrite;
   logic              mem_memRead;
   logic [31:0]       mem_readData;

   logic              busy;
   logic              grant_id;

   modport slave (
      input  p0_req, p0_we, p0_addr, p0_wdata,
      input  p1_req, p1_we, p1_addr, p1_wdata,
      input  mem_readData,
      output p0_ack, p0_err, p0_rdata,
      output p1_ack, p1_err, p1_rdata,
      output mem_address, mem_writeData, mem_memWrite, mem_memRead,
      output busy, grant_id
   );

   modport master (
      output p0_req, p0_we, p0_addr, p0_wdata,
      output p1_req, p1_we, p1_addr, p1_wdata,
      output mem_readData,
      input  p0_ack, p0_err, p0_rdata,
      input  p1_ack, p1_err, p1_rdata,
      input  mem_address, mem_writeData, mem_memWrite, mem_memRead,
      input  busy, grant_id
   );
endinterface

// File: rtl/data_mem_arbiter.sv
// Round-robin two-port sequencer for a single-ported data memory: grant -> ACCESS -> RESP,
// ack two cycles after the granting edge; requesters wait by holding req until their ack.
module data_mem_arbiter #(
   parameter int MEM_DEPTH = 128,
   parameter int ADDR_W    = 32
) (
   input logic               clock_in,
   input logic               reset,
   data_mem_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t            state_q, state_d;
   logic              last_grant_q, last_grant_d;
   logic              grant_q, grant_d;
   logic              we_q, we_d;
   logic              oor_q, oor_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       p0_rdata_q, p0_rdata_d;
   logic [31:0]       p1_rdata_q, p1_rdata_d;
   logic              win;

   always_ff @(posedge clock_in or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         grant_q      <= 1'b0;
         we_q         <= 1'b0;
         oor_q        <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         p0_rdata_q   <= '0;
         p1_rdata_q   <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         grant_q      <= grant_d;
         we_q         <= we_d;
         oor_q        <= oor_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         p0_rdata_q   <= p0_rdata_d;
         p1_rdata_q   <= p1_rdata_d;
      end
   end

   always_comb begin
      state_d           = state_q;
      last_grant_d      = last_grant_q;
      grant_d           = grant_q;
      we_d              = we_q;
      oor_d             = oor_q;
      addr_d            = addr_q;
      wdata_d           = wdata_q;
      p0_rdata_d        = p0_rdata_q;
      p1_rdata_d        = p1_rdata_q;
      win               = 1'b0;
      bus.mem_address   = '0;
      bus.mem_writeData = '0;
      bus.mem_memWrite  = 1'b0;
      bus.mem_memRead   = 1'b0;
      bus.p0_ack        = 1'b0;
      bus.p0_err        = 1'b0;
      bus.p1_ack        = 1'b0;
      bus.p1_err        = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.p0_req || bus.p1_req) begin
               // On a tie the port that did not win last time goes first.
               win          = (bus.p0_req && bus.p1_req) ? ~last_grant_q : bus.p1_req;
               grant_d      = win;
               last_grant_d = win;
               we_d         = win ? bus.p1_we    : bus.p0_we;
               addr_d       = win ? bus.p1_addr  : bus.p0_addr;
               wdata_d      = win ? bus.p1_wdata : bus.p0_wdata;
               oor_d        = (win ? bus.p1_addr : bus.p0_addr) >= ADDR_W'(MEM_DEPTH);
               state_d      = ACCESS;
            end
         end
         ACCESS: begin
            bus.mem_address = addr_q;
            if (!oor_q) begin
               if (we_q) begin
                  bus.mem_memWrite  = 1'b1;
                  bus.mem_writeData = wdata_q;
               end else begin
                  bus.mem_memRead = 1'b1;
               end
            end
            // Out-of-range accesses of either kind clear the port's read data.
            if (oor_q || !we_q) begin
               if (grant_q) p1_rdata_d = oor_q ? 32'h0 : bus.mem_readData;
               else         p0_rdata_d = oor_q ? 32'h0 : bus.mem_readData;
            end
            state_d = RESP;
         end
         RESP: begin
            bus.p0_ack = ~grant_q;
            bus.p0_err = ~grant_q & oor_q;
            bus.p1_ack = grant_q;
            bus.p1_err = grant_q & oor_q;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.p0_rdata = p0_rdata_q;
   assign bus.p1_rdata = p1_rdata_q;
   assign bus.busy     = (state_q != IDLE);
   assign bus.grant_id = grant_q;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: table of single accesses, tie/fairness rounds and a reset
// landing in the middle of an ACCESS cycle, with acks checked against a scoreboard queue.
module tb_data_mem_arbiter;
   logic clock_in;
   logic reset;

   data_mem_arbiter_if #(.ADDR_W(32)) bus ();

   data_mem_arbiter #(.MEM_DEPTH(128), .ADDR_W(32)) dut (
      .clock_in (clock_in),
      .reset    (reset),
      .bus      (bus.slave)
   );

   initial clock_in = 1'b0;
   always #5 clock_in = ~clock_in;

   typedef struct {
      logic        port;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        err;
      logic        hold;
      logic [31:0] rdata;
   } vec_t;

   typedef struct {
      logic        port;
      logic        err;
      logic [31:0] rdata;
      int          cyc;
   } exp_t;

   logic [31:0] mem_arr [128];
   logic [31:0] last_rd [2];
   exp_t        sbq [$];
   vec_t        vt [11];
   int          cyc = 0;
   int          n_wr = 0;
   int          n_cmp = 0;
   int          n_fail = 0;

   // Memory model: combinational read, write committed on the negedge.
   assign bus.mem_readData = (bus.mem_address < 32'd128) ? mem_arr[bus.mem_address[6:0]] : 32'h0;

   always @(negedge clock_in) begin
      if (bus.mem_memWrite) begin
         if (bus.mem_address < 32'd128) mem_arr[bus.mem_address[6:0]] = bus.mem_writeData;
         n_wr++;
      end
   end

   always @(posedge clock_in) cyc <= cyc + 1;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic void check_ack(logic port, logic err, logic [31:0] rdata);
      exp_t e;
      if (sbq.size() == 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL unexpected_ack: got ack on port %0d, expected none (cycle %0d)", port, cyc);
      end else begin
         e = sbq.pop_front();
         chk("ack_port", 32'(port), 32'(e.port));
         chk("ack_err", 32'(err), 32'(e.err));
         chk("ack_rdata", rdata, e.rdata);
         chk("ack_cycle", cyc, e.cyc);
      end
   endfunction

   always @(negedge clock_in) begin
      if (reset) begin
         if (bus.p0_ack) check_ack(1'b0, bus.p0_err, bus.p0_rdata);
         if (bus.p1_ack) check_ack(1'b1, bus.p1_err, bus.p1_rdata);
      end
   end

   function automatic void check_quiet(string tag);
      chk({tag, "_p0_ack"},   32'(bus.p0_ack), 0);
      chk({tag, "_p0_err"},   32'(bus.p0_err), 0);
      chk({tag, "_p0_rdata"}, bus.p0_rdata, 0);
      chk({tag, "_p1_ack"},   32'(bus.p1_ack), 0);
      chk({tag, "_p1_err"},   32'(bus.p1_err), 0);
      chk({tag, "_p1_rdata"}, bus.p1_rdata, 0);
      chk({tag, "_mem_addr"}, bus.mem_address, 0);
      chk({tag, "_mem_wdat"}, bus.mem_writeData, 0);
      chk({tag, "_mem_wr"},   32'(bus.mem_memWrite), 0);
      chk({tag, "_mem_rd"},   32'(bus.mem_memRead), 0);
      chk({tag, "_busy"},     32'(bus.busy), 0);
      chk({tag, "_grant_id"}, 32'(bus.grant_id), 0);
   endfunction

   task automatic apply(input vec_t v);
      exp_t        e;
      logic [31:0] er;
      logic        done;
      @(negedge clock_in);
      er = v.hold ? last_rd[v.port] : v.rdata;
      last_rd[v.port] = er;
      e = '{v.port, v.err, er, cyc + 2};
      sbq.push_back(e);
      if (v.port) begin
         bus.p1_req = 1'b1; bus.p1_we = v.we; bus.p1_addr = v.addr; bus.p1_wdata = v.wdata;
      end else begin
         bus.p0_req = 1'b1; bus.p0_we = v.we; bus.p0_addr = v.addr; bus.p0_wdata = v.wdata;
      end
      @(negedge clock_in);
      chk("acc_mem_rd",   32'(bus.mem_memRead),  32'(!v.we && !v.err));
      chk("acc_mem_wr",   32'(bus.mem_memWrite), 32'(v.we && !v.err));
      chk("acc_mem_addr", bus.mem_address, v.addr);
      chk("acc_mem_wdat", bus.mem_writeData, (v.we && !v.err) ? v.wdata : 32'h0);
      chk("acc_grant_id", 32'(bus.grant_id), 32'(v.port));
      chk("acc_busy",     32'(bus.busy), 1);
      done = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clock_in);
         if (v.port ? bus.p1_ack : bus.p0_ack) begin
            done = 1'b1;
            break;
         end
      end
      bus.p0_req = 1'b0;
      bus.p1_req = 1'b0;
      chk("ack_seen", 32'(done), 1);
      chk("resp_mem_rd", 32'(bus.mem_memRead | bus.mem_memWrite), 0);
   endtask

   task automatic tie_round(input int a0, input int a1);
      exp_t e0, e1;
      logic d0, d1;
      @(negedge clock_in);
      e0 = '{1'b0, 1'b0, mem_arr[a0], cyc + 2};
      e1 = '{1'b1, 1'b0, mem_arr[a1], cyc + 5};
      sbq.push_back(e0);
      sbq.push_back(e1);
      last_rd[0] = e0.rdata;
      last_rd[1] = e1.rdata;
      bus.p0_req = 1'b1; bus.p0_we = 1'b0; bus.p0_addr = 32'(a0);
      bus.p1_req = 1'b1; bus.p1_we = 1'b0; bus.p1_addr = 32'(a1);
      d0 = 1'b0;
      d1 = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clock_in);
         if (bus.p0_ack) begin d0 = 1'b1; bus.p0_req = 1'b0; end
         if (bus.p1_ack) begin d1 = 1'b1; bus.p1_req = 1'b0; end
         if (d0 && d1) break;
      end
      bus.p0_req = 1'b0;
      bus.p1_req = 1'b0;
      chk("tie_both_acked", 32'({d0, d1}), 32'h3);
   endtask

   initial begin
      for (int i = 0; i < 128; i++) mem_arr[i] = 32'(i);
      last_rd[0] = 0;
      last_rd[1] = 0;
      //       port  we    addr     wdata         err   hold  rdata
      vt[0]  = '{1'b0, 1'b0, 32'd5,   32'h0,        1'b0, 1'b0, 32'd5};
      vt[1]  = '{1'b1, 1'b1, 32'd3,   32'hDEADBEEF, 1'b0, 1'b1, 32'h0};
      vt[2]  = '{1'b1, 1'b0, 32'd3,   32'h0,        1'b0, 1'b0, 32'hDEADBEEF};
      vt[3]  = '{1'b0, 1'b1, 32'd200, 32'h11111111, 1'b1, 1'b0, 32'h0};
      vt[4]  = '{1'b0, 1'b0, 32'd127, 32'h0,        1'b0, 1'b0, 32'd127};
      vt[5]  = '{1'b1, 1'b0, 32'd128, 32'h0,        1'b1, 1'b0, 32'h0};
      vt[6]  = '{1'b0, 1'b1, 32'd0,   32'hA5A5A5A5, 1'b0, 1'b1, 32'h0};
      vt[7]  = '{1'b0, 1'b0, 32'd0,   32'h0,        1'b0, 1'b0, 32'hA5A5A5A5};
      vt[8]  = '{1'b1, 1'b0, 32'd72,  32'h0,        1'b0, 1'b0, 32'd72};
      vt[9]  = '{1'b1, 1'b1, 32'd127, 32'hCAFEF00D, 1'b0, 1'b1, 32'h0};
      vt[10] = '{1'b0, 1'b0, 32'd127, 32'h0,        1'b0, 1'b0, 32'hCAFEF00D};

      reset = 1'b0;
      bus.p0_req = 1'b0; bus.p0_we = 1'b0; bus.p0_addr = '0; bus.p0_wdata = '0;
      bus.p1_req = 1'b0; bus.p1_we = 1'b0; bus.p1_addr = '0; bus.p1_wdata = '0;
      #1;
      check_quiet("rst");
      @(negedge clock_in);
      reset = 1'b1;

      // Ties straight out of reset: port 0 first every round.
      tie_round(1, 2);
      tie_round(3, 4);
      tie_round(5, 6);

      for (int i = 0; i < 11; i++) apply(vt[i]);
      chk("write_pulses", n_wr, 3);

      // Reset landing inside a port 0 write ACCESS cycle.
      @(negedge clock_in);
      bus.p0_req = 1'b1; bus.p0_we = 1'b1; bus.p0_addr = 32'd10; bus.p0_wdata = 32'h12345678;
      @(posedge clock_in);
      #2;
      chk("pre_rst_busy", 32'(bus.busy), 1);
      reset = 1'b0;
      #1;
      check_quiet("mid_rst");
      bus.p0_req = 1'b0;
      last_rd[0] = 0;
      last_rd[1] = 0;
      repeat (2) @(negedge clock_in);
      reset = 1'b1;
      tie_round(20, 30);

      repeat (3) @(negedge clock_in);
      chk("sb_drained", sbq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-port arbiter and access sequencer for the single-ported `data_memory` block. It shares the memory between port 0 (CPU load/store stage) and port 1 (debug/DMA loader) with round-robin fairness. It drives the memory's `address`/`writeData`/`memWrite`/`memRead` pins and returns read data through a req/ack handshake. It sits between the pipeline's MEM stage, the loader, and the `data_memory` instance.

## Interface
Parameters:
- `MEM_DEPTH`, 128: number of 32-bit words in the memory; valid word addresses are 0..MEM_DEPTH-1.
- `ADDR_W`, 32: width of all address buses.

Ports:
- `clock_in`  in  1  system clock; all state updates on posedge.
- `reset`  in  1  one clock; reset is asynchronous and active-low.
- `p0_req`  in  1  port 0 request; held high with fields stable until `p0_ack`.
- `p0_we`  in  1  port 0: 1 = write, 0 = read.
- `p0_addr`  in  ADDR_W  port 0 word address.
- `p0_wdata`  in  32  port 0 write data.
- `p0_ack`  out  1  one-cycle completion pulse.
- `p0_err`  out  1  pulses with `p0_ack` when the address was out of range.
- `p0_rdata`  out  32  read result; registered and held until the next port 0 read ack.
- `p1_req`, `p1_we`, `p1_addr`, `p1_wdata`, `p1_ack`, `p1_err`, `p1_rdata`: same as port 0, for port 1.
- `mem_address`  out  ADDR_W  to the memory's `address` pin.
- `mem_writeData`  out  32  to the memory's `writeData` pin.
- `mem_memWrite`  out  1  to the memory's `memWrite` pin.
- `mem_memRead`  out  1  to the memory's `memRead` pin.
- `mem_readData`  in  32  from the memory's `readData` pin.
- `busy`  out  1  high in ACCESS and RESP.
- `grant_id`  out  1  port currently or last served.

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- IDLE:
  - If any `pN_req` is high, latch the winner's we/addr/wdata into internal registers and go to ACCESS.
  - The winner is the requesting port if only one requests.
  - If both request, the winner is the port != `last_grant`. `last_grant` resets to 1, so port 0 wins the first tie.
  - Update `last_grant` and `grant_id` to the winner.
- ACCESS (exactly one cycle):
  - `mem_address` = latched addr.
  - Write: `mem_memWrite`=1, `mem_writeData`=wdata. The memory commits on the negedge inside this cycle.
  - Read: `mem_memRead`=1.
  - Then go to RESP.
- RESP (one cycle):
  - The winner's `ack`=1.
  - For a read, `rdata` is loaded from `mem_readData` (sampled at the ACCESS→RESP edge).
  - Then go to IDLE.
- Out-of-range (latched addr >= MEM_DEPTH): in ACCESS, both `mem_memWrite` and `mem_memRead` stay 0 and memory is untouched. In RESP, `ack`=1, `err`=1, and `rdata` is loaded with 0.
- Memory pins outside ACCESS: all zero (`mem_address`=0, `mem_writeData`=0, strobes 0).
- The requester lowers `req` after seeing `ack`. Because the FSM always returns to IDLE, a `req` still high in the ack cycle is never re-granted.
- Requests that change fields while waiting are legal; the values present at the granting edge are used.
- Reset values (async, while `reset`=0):
  - All outputs 0, including both `rdata` and `grant_id`.
  - state=IDLE, `last_grant`=1.

## Timing
- Latency:
  - `req` high at posedge N (FSM in IDLE): ACCESS in cycle N+1, `ack` in cycle N+2.
  - Read data is valid on `rdata` from cycle N+2 onward.
- Throughput: one access per 3 cycles. The losing port of a tie is granted at the IDLE edge right after the winner's RESP, so its `ack` arrives 3 cycles after the winner's.
- `mem_memWrite` is high for exactly one full clock period, so exactly one negedge write occurs per write access.
- Reset asserted mid-ACCESS:
  - Strobes drop immediately (asynchronously); the write may or may not have landed and is not guaranteed.
  - No `ack` is produced; the requester must re-issue.
- Reset deasserted: the first grant can occur at the first posedge after release.

## Test plan
- Single read: p0 read addr 5 with mem word 5 = 0x5 → `mem_memRead` high in cycle 1 only, `p0_ack` in cycle 2, `p0_rdata`=0x5, `grant_id`=0.
- Single write then read: p1 writes 0xDEADBEEF to addr 3, then reads addr 3 → `mem_memWrite` high exactly one cycle, then `p1_rdata`=0xDEADBEEF.
- Tie and fairness: both ports request reads in the same cycle, three times back-to-back → service order 0,1,0,1,0,1; acks 3 cycles apart; no port acked twice per request.
- Out of range: p0 write to addr 200 → no `mem_memWrite` pulse, `p0_ack`=`p0_err`=1, `p0_rdata`=0, memory contents unchanged.
- Reset mid-ACCESS: assert `reset`=0 during a p0 write ACCESS cycle → all outputs 0 immediately and no `ack`; after release, p1 and p0 tie → p0 granted first.
